// File: rtl/unified_mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
package unified_mem_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DM_WAIT,
    S_IF_ISSUE,
    S_IF_WAIT,
    S_DONE
  } arb_state_e;

  // Counter width; LAT must fit (1..7).
  localparam int LAT_W = 3;

  // When both stages request together, the data access goes first.
  localparam bit DM_FIRST = 1'b1;

endpackage

// File: rtl/arb_lat_counter.sv
// Read-latency counter: load starts at 1, inc steps, otherwise clears; done when count reaches LAT.
module arb_lat_counter
  import unified_mem_arb_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic done
);

  logic [LAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (load)     cnt_d = LAT_W'(1);
    else if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == LAT_W'(LAT));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises IF and MEM stage requests onto one fixed-latency memory port,
// stalling the pipeline until every request of the cycle has been served.
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int LAT = 2,
  parameter int AW  = 64,
  parameter int DW  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          stall_pipe,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_e    state_q, state_d;
  logic          dm_served_q, dm_served_d;
  logic          if_served_q, if_served_d;
  logic [DW-1:0] dm_hold_q, dm_hold_d;
  logic [31:0]   if_hold_q, if_hold_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          cnt_load, cnt_inc, cnt_done;
  logic          dm_sel;
  logic          unused_addr_bits;

  function automatic logic [AW-1:0] dw_align(input logic [AW-1:0] a);
    return {a[AW-1:3], 3'b000};
  endfunction

  assign dm_sel           = dm_req && (DM_FIRST || !if_req);
  assign unused_addr_bits = ^{dm_addr[2:0], if_addr[1:0]};

  arb_lat_counter #(.LAT(LAT)) u_lat_cnt (
    .clk  (clk),
    .rst  (reset),
    .load (cnt_load),
    .inc  (cnt_inc),
    .done (cnt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dm_served_q <= 1'b0;
      if_served_q <= 1'b0;
      dm_hold_q   <= '0;
      if_hold_q   <= '0;
      dm_rdata_q  <= '0;
      if_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      dm_served_q <= dm_served_d;
      if_served_q <= if_served_d;
      dm_hold_q   <= dm_hold_d;
      if_hold_q   <= if_hold_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dm_served_d = dm_served_q;
    if_served_d = if_served_q;
    dm_hold_d   = dm_hold_q;
    if_hold_d   = if_hold_q;
    cnt_load    = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dm_sel) begin
          dm_served_d = 1'b1;
          if (dm_we) begin
            state_d = if_req ? S_IF_ISSUE : S_DONE;
          end else begin
            state_d  = S_DM_WAIT;
            cnt_load = 1'b1;
          end
        end else if (if_req) begin
          if_served_d = 1'b1;
          state_d     = S_IF_WAIT;
          cnt_load    = 1'b1;
        end
      end
      S_DM_WAIT: begin
        if (cnt_done) begin
          dm_hold_d = mem_rdata;
          state_d   = if_req ? S_IF_ISSUE : S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_IF_ISSUE: begin
        if_served_d = 1'b1;
        state_d     = S_IF_WAIT;
        cnt_load    = 1'b1;
      end
      S_IF_WAIT: begin
        if (cnt_done) begin
          if_hold_d = if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          state_d   = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        dm_served_d = 1'b0;
        if_served_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Result registers pick up the holding values on entry to DONE so they are
    // stable for the whole release cycle and hold afterwards.
    dm_rdata_d = (state_d == S_DONE && dm_served_d) ? dm_hold_d : dm_rdata_q;
    if_rdata_d = (state_d == S_DONE && if_served_d) ? if_hold_d : if_rdata_q;
  end

  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    stall_pipe = 1'b1;
    if_valid   = 1'b0;
    dm_valid   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        stall_pipe = dm_req | if_req;
        if (dm_sel) begin
          mem_en    = 1'b1;
          mem_we    = dm_we;
          mem_addr  = dw_align(dm_addr);
          mem_wdata = dm_we ? dm_wdata : '0;
        end else if (if_req) begin
          mem_en   = 1'b1;
          mem_addr = dw_align(if_addr);
        end
      end
      S_IF_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = dw_align(if_addr);
      end
      S_DONE: begin
        stall_pipe = 1'b0;
        if_valid   = if_served_q;
        dm_valid   = dm_served_q;
      end
      default: ;
    endcase
  end

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: three arbiter builds (LAT=2,1,7) against a small latency-accurate memory model.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_if_req[3], s_dm_req[3], s_dm_we[3];
  logic [63:0] s_if_addr[3], s_dm_addr[3], s_dm_wdata[3], s_dm_rdata[3];
  logic [63:0] s_mem_addr[3], s_mem_wdata[3], s_mem_rdata[3];
  logic [31:0] s_if_rdata[3];
  logic        s_if_valid[3], s_dm_valid[3], s_stall[3], s_mem_en[3], s_mem_we[3];
  logic [63:0] mem [128];
  int          n_chk, n_fail;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 7;
    logic [63:0] pipe [L];

    unified_mem_arbiter #(.LAT(L), .AW(64), .DW(64)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .if_req     (s_if_req[g]),
      .if_addr    (s_if_addr[g]),
      .if_rdata   (s_if_rdata[g]),
      .if_valid   (s_if_valid[g]),
      .dm_req     (s_dm_req[g]),
      .dm_we      (s_dm_we[g]),
      .dm_addr    (s_dm_addr[g]),
      .dm_wdata   (s_dm_wdata[g]),
      .dm_rdata   (s_dm_rdata[g]),
      .dm_valid   (s_dm_valid[g]),
      .stall_pipe (s_stall[g]),
      .mem_en     (s_mem_en[g]),
      .mem_we     (s_mem_we[g]),
      .mem_addr   (s_mem_addr[g]),
      .mem_wdata  (s_mem_wdata[g]),
      .mem_rdata  (s_mem_rdata[g])
    );

    // Read data is valid only L cycles after the issue cycle; junk otherwise.
    always @(posedge clk) begin
      pipe[0] <= (s_mem_en[g] && !s_mem_we[g]) ? mem[s_mem_addr[g][9:3]] : {$urandom, $urandom};
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign s_mem_rdata[g] = pipe[L-1];
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= 64'(i) * 64'h0001_0001_0001_0001;
      mem[7'h20] <= 64'hAAAA_BBBB_1234_5678;
      mem[7'h40] <= 64'h55;
      mem[7'h00] <= 64'h8B02_0001;
    end else if (s_mem_en[0] && s_mem_we[0]) begin
      mem[s_mem_addr[0][9:3]] <= s_mem_wdata[0];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int g);
    s_if_req[g] = 1'b0;
    s_dm_req[g] = 1'b0;
    s_dm_we[g]  = 1'b0;
  endtask

  task automatic quiet(input string tag);
    chk(tag, {s_stall[0], s_mem_en[0], s_if_valid[0], s_dm_valid[0]}, 4'b0000);
  endtask

  // Read 0x200 + fetch 0x0 on build g; count cycles to DONE.
  task automatic run_rf(input int g, input int exp_done, input string tag);
    int done_c;
    s_dm_req[g] = 1'b1; s_dm_we[g] = 1'b0; s_dm_addr[g] = 64'h200;
    s_if_req[g] = 1'b1; s_if_addr[g] = 64'h0;
    #1;
    done_c = -1;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (s_dm_valid[g]) begin done_c = c; break; end
    end
    chk({tag, "_done_cycle"}, 64'(done_c), 64'(exp_done));
    chk({tag, "_ifv"}, s_if_valid[g], 1'b1);
    chk({tag, "_dm_rdata"}, s_dm_rdata[g], 64'h55);
    chk({tag, "_if_rdata"}, s_if_rdata[g], 32'h8B02_0001);
    clr(g);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      clr(g);
      s_if_addr[g] = '0; s_dm_addr[g] = '0; s_dm_wdata[g] = '0;
    end
    repeat (3) tick;
    quiet("rst_ctrl");
    chk("rst_if_rdata", s_if_rdata[0], 32'h0);
    chk("rst_dm_rdata", s_dm_rdata[0], 64'h0);
    reset = 1'b0;
    tick;

    // Lone fetch from the upper word.
    s_if_req[0] = 1'b1; s_if_addr[0] = 64'h104; #1;
    chk("f0_stall", s_stall[0], 1'b1);
    chk("f0_en", s_mem_en[0], 1'b1);
    chk("f0_addr", s_mem_addr[0], 64'h100);
    tick; chk("f1_stall", s_stall[0], 1'b1); chk("f1_en", s_mem_en[0], 1'b0);
    tick; chk("f2_stall", s_stall[0], 1'b1); chk("f2_ifv", s_if_valid[0], 1'b0);
    tick; chk("f3_stall", s_stall[0], 1'b0); chk("f3_ifv", s_if_valid[0], 1'b1);
    chk("f3_dmv", s_dm_valid[0], 1'b0);
    chk("f3_if_rdata", s_if_rdata[0], 32'hAAAA_BBBB);
    clr(0);
    tick; chk("f4_ifv", s_if_valid[0], 1'b0); chk("f4_hold", s_if_rdata[0], 32'hAAAA_BBBB);

    // Simultaneous read + fetch: data first, fetch issued in cycle 3.
    s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b0; s_dm_addr[0] = 64'h200;
    s_if_req[0] = 1'b1; s_if_addr[0] = 64'h0; #1;
    chk("rf0_en", s_mem_en[0], 1'b1);
    chk("rf0_we", s_mem_we[0], 1'b0);
    chk("rf0_addr", s_mem_addr[0], 64'h200);
    for (int c = 1; c <= 6; c++) begin
      tick;
      chk($sformatf("rf%0d_stall", c), s_stall[0], c < 6);
      chk($sformatf("rf%0d_en", c), s_mem_en[0], c == 3);
      chk($sformatf("rf%0d_valids", c), {s_dm_valid[0], s_if_valid[0]}, (c == 6) ? 2'b11 : 2'b00);
      if (c == 3) chk("rf3_addr", s_mem_addr[0], 64'h0);
    end
    chk("rf6_dm_rdata", s_dm_rdata[0], 64'h55);
    chk("rf6_if_rdata", s_if_rdata[0], 32'h8B02_0001);
    clr(0);
    tick;

    // Store + fetch of the lower word; store address low bits dropped.
    s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b1; s_dm_addr[0] = 64'h1F; s_dm_wdata[0] = 64'hDEAD;
    s_if_req[0] = 1'b1; s_if_addr[0] = 64'h100; #1;
    chk("sf0_we", s_mem_we[0], 1'b1);
    chk("sf0_addr", s_mem_addr[0], 64'h18);
    chk("sf0_wdata", s_mem_wdata[0], 64'hDEAD);
    tick;
    chk("sf1_en", s_mem_en[0], 1'b1); chk("sf1_we", s_mem_we[0], 1'b0);
    chk("sf1_addr", s_mem_addr[0], 64'h100); chk("sf1_wdata", s_mem_wdata[0], 64'h0);
    for (int c = 2; c <= 3; c++) begin
      tick;
      chk($sformatf("sf%0d_stall", c), s_stall[0], 1'b1);
      chk($sformatf("sf%0d_valids", c), {s_dm_valid[0], s_if_valid[0]}, 2'b00);
    end
    tick;
    chk("sf4_stall", s_stall[0], 1'b0);
    chk("sf4_valids", {s_dm_valid[0], s_if_valid[0]}, 2'b11);
    chk("sf4_if_rdata", s_if_rdata[0], 32'h1234_5678);
    clr(0);
    tick;

    // Lone write (1 cycle), then a read raised during DONE waits for IDLE.
    s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b1; s_dm_addr[0] = 64'h40;
    s_dm_wdata[0] = 64'h1122_3344_5566_7788; #1;
    chk("w0_en", s_mem_en[0], 1'b1);
    tick;
    chk("w1_stall", s_stall[0], 1'b0);
    chk("w1_valids", {s_dm_valid[0], s_if_valid[0]}, 2'b10);
    s_dm_we[0] = 1'b0; s_dm_addr[0] = 64'h47; #1;
    chk("w1_no_issue", s_mem_en[0], 1'b0);
    tick;
    chk("r0_en", s_mem_en[0], 1'b1); chk("r0_addr", s_mem_addr[0], 64'h40);
    tick; tick; chk("r2_dmv", s_dm_valid[0], 1'b0);
    tick; chk("r3_dmv", s_dm_valid[0], 1'b1);
    chk("r3_dm_rdata", s_dm_rdata[0], 64'h1122_3344_5566_7788);
    clr(0);
    tick;

    for (int c = 0; c < 10; c++) begin
      quiet($sformatf("idle%0d", c));
      tick;
    end

    // Reset during DM_WAIT: async clear, late read data ignored.
    s_dm_req[0] = 1'b1; s_dm_we[0] = 1'b0; s_dm_addr[0] = 64'h200;
    tick;
    chk("rm1_stall", s_stall[0], 1'b1);
    #2; reset = 1'b1; clr(0); #1;
    quiet("rm_async");
    chk("rm_dm_rdata", s_dm_rdata[0], 64'h0);
    chk("rm_if_rdata", s_if_rdata[0], 32'h0);
    tick; tick;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      quiet($sformatf("rm_post%0d", c));
    end

    run_rf(0, 6, "lat2");
    run_rf(1, 4, "lat1");
    run_rf(2, 16, "lat7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between two pipeline requesters: instruction fetch (read-only) and data memory (read/write).
- Sits between the IF and MEM stages and the memory macro.
- When both stages request in the same cycle, it serialises them, data first.
- It asserts a pipeline stall until every request presented in that cycle has been served, then releases the results for one cycle.

Parameters:
- LAT, 2: memory read latency in cycles (mem_rdata valid LAT cycles after the issue cycle); legal range 1..7.
- AW, 64: address width.
- DW, 64: memory/data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held stable while stall_pipe=1.
- if_addr  in  AW  fetch byte address; held stable while stall_pipe=1.
- if_rdata  out  32  fetched instruction.
- if_valid  out  1  if_rdata valid (DONE cycle only).
- dm_req  in  1  data request; held stable while stall_pipe=1.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  AW  data byte address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data.
- dm_valid  out  1  dm access complete (DONE cycle only).
- stall_pipe  out  1  freeze all pipeline registers and the PC.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  doubleword-aligned address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data; valid exactly LAT cycles after the mem_en read cycle.

Behaviour:
- States: IDLE, DM_WAIT, IF_ISSUE, IF_WAIT, DONE. All registers reset asynchronously.
- Reset values:
  - state=IDLE, lat_cnt=0.
  - Holding registers, if_rdata, dm_rdata = 0.
  - if_valid=0, dm_valid=0.
  - Served flags = 0.
- mem_* outputs are combinational from state and the held request inputs. When mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
- mem_addr = {addr[AW-1:3], 3'b000} for both requesters. Low 3 address bits are ignored for data accesses.
- IDLE:
  - dm_req=1: issue DM (mem_en=1, mem_we=dm_we, stall_pipe=1).
    - Write: next state is IF_ISSUE if if_req, else DONE.
    - Read: next state is DM_WAIT, lat_cnt=1.
  - dm_req=0, if_req=1: issue IF read, stall_pipe=1, next state IF_WAIT, lat_cnt=1.
  - Neither request: stall_pipe=0, stay in IDLE.
- DM_WAIT:
  - stall_pipe=1, mem_en=0, lat_cnt increments.
  - When lat_cnt==LAT, capture mem_rdata into the dm holding register.
  - Next state is IF_ISSUE if if_req, else DONE.
- IF_ISSUE: issue IF read, stall_pipe=1, next state IF_WAIT, lat_cnt=1.
- IF_WAIT:
  - Same counting as DM_WAIT.
  - At lat_cnt==LAT, capture the instruction word: mem_rdata[31:0] if if_addr[2]=0, else mem_rdata[63:32] (little-endian).
  - Next state DONE.
- DONE:
  - stall_pipe=0.
  - if_valid=1 iff a fetch was served this transaction; dm_valid=1 iff a data access was served (reads and writes).
  - Data outputs show the holding registers.
  - Next state is IDLE; served flags clear.
  - Valid outputs are 0 in every other state. Data outputs hold their last value.
- Latency from request seen in IDLE to DONE, LAT=2:
  - Lone read: 3 cycles.
  - Lone write: 1 cycle.
  - Write + fetch: 4 cycles.
  - Read + fetch: 6 cycles.
- New requests raised in the DONE cycle are evaluated in the following IDLE cycle. There is no back-to-back issue from DONE.
- Reset mid-transaction: immediately return to IDLE with valids=0. mem_rdata arriving afterwards is ignored, because the counter has been cleared.
- Requests dropped mid-transaction (protocol violation) do not abort: the FSM completes the sequence it started.

Decomposition:
- Package unified_mem_arb_pkg: state enum, the LAT_W counter width constant (3 bits), and the DM-before-IF priority constant.
- One sub-module, arb_lat_counter: loadable up-counter with a done==LAT compare, async reset.

Test Plan:
- Lone fetch, LAT=2: if_req=1, if_addr=0x104, mem returns 0xAAAA_BBBB_1234_5678 at cycle 2 -> stall_pipe 1,1,1,0; if_rdata=0xAAAABBBB; if_valid=1 in cycle 3 only.
- Simultaneous read+fetch: dm read 0x200 (mem returns 0x55), fetch 0x0 (returns 0x8B02_0001) -> mem_en at cycles 0 and 3 with addresses 0x200 then 0x0; DONE at cycle 6 with dm_rdata=0x55, if_rdata=0x8B020001, both valids=1.
- Store+fetch: dm_we=1, dm_addr=0x1F, dm_wdata=0xDEAD -> cycle 0 mem_we=1, mem_addr=0x18, mem_wdata=0xDEAD; IF issued at cycle 1; DONE at cycle 4 with dm_valid=1.
- Idle: no requests for 10 cycles -> stall_pipe=0, mem_en=0, valids=0 throughout.
- Reset asserted mid DM_WAIT -> outputs zero asynchronously; after release with no request, IDLE with no spurious valid, even though mem_rdata toggles.
- LAT=1 and LAT=7 builds: read+fetch DONE at cycles 4 and 16 respectively.
